// File: rtl/quad_encoder_counter_if.sv
// Signal bundle between the encoder pins/control logic and quad_encoder_counter.
// index_in/index_seen exist only when QENC_INDEX_EN is defined.
interface quad_encoder_counter_if #(
   parameter int CNT_W = 16,
   parameter int VEL_W = 12
);
   logic             a_in;
   logic             b_in;
   logic             clear;
   logic             err_clr;
   logic [CNT_W-1:0] count;
   logic             step;
   logic             dir;
   logic             err;
   logic             ovf;
   logic [VEL_W-1:0] velocity;
   logic             vel_valid;
`ifdef QENC_INDEX_EN
   logic             index_in;
   logic             index_seen;

   modport master (
      output a_in, b_in, clear, err_clr, index_in,
      input  count, step, dir, err, ovf, velocity, vel_valid, index_seen
   );
   modport slave (
      input  a_in, b_in, clear, err_clr, index_in,
      output count, step, dir, err, ovf, velocity, vel_valid, index_seen
   );
`else
   modport master (
      output a_in, b_in, clear, err_clr,
      input  count, step, dir, err, ovf, velocity, vel_valid
   );
   modport slave (
      input  a_in, b_in, clear, err_clr,
      output count, step, dir, err, ovf, velocity, vel_valid
   );
`endif
endinterface

// File: rtl/quad_encoder_counter.sv
// Quadrature decoder: pin sync, glitch filter, 4x decode, signed position, windowed velocity.
// Define QENC_INDEX_EN to add the index input (zeroes count) and sticky index_seen output.
module quad_encoder_counter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4,
   parameter int CNT_W       = 16,
   parameter int SATURATE    = 0,
   parameter int VEL_WINDOW  = 1000,
   parameter int VEL_W       = 12
) (
   input logic                   clk,
   input logic                   reset,
   quad_encoder_counter_if.slave bus
);

   localparam int STAB_W = $clog2(FILTER_LEN + 1);
   localparam int WIN_W  = $clog2(VEL_WINDOW);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic [CNT_W-1:0]  CNT_MIN   = {1'b1, {(CNT_W-1){1'b0}}};
   localparam logic [VEL_W-1:0]  VEL_MAX   = {1'b0, {(VEL_W-1){1'b1}}};
   localparam logic [VEL_W-1:0]  VEL_MIN   = {1'b1, {(VEL_W-1){1'b0}}};
   localparam logic [STAB_W-1:0] STAB_FULL = STAB_W'(FILTER_LEN);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(VEL_WINDOW - 1);
   localparam logic [1:0] MV_NONE = 2'd0;
   localparam logic [1:0] MV_UP   = 2'd1;
   localparam logic [1:0] MV_DN   = 2'd2;
   localparam logic [1:0] MV_ILL  = 2'd3;

   typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   // Classify an {A,B} transition on the Gray cycle 00->01->11->10->00.
   function automatic logic [1:0] decode_move(input logic [1:0] old_ab, input logic [1:0] new_ab);
      logic [1:0] mv;
      case ({old_ab, new_ab})
         4'b0001, 4'b0111, 4'b1110, 4'b1000: mv = MV_UP;
         4'b0100, 4'b1101, 4'b1011, 4'b0010: mv = MV_DN;
         4'b0011, 4'b1100, 4'b0110, 4'b1001: mv = MV_ILL;
         default:                            mv = MV_NONE;
      endcase
      return mv;
   endfunction

   function automatic logic [VEL_W-1:0] vel_add(input logic [VEL_W-1:0] acc, input logic inc,
                                                input logic up);
      logic [VEL_W-1:0] res;
      if (!inc)      res = acc;
      else if (up)   res = (acc == VEL_MAX) ? VEL_MAX : acc + VEL_W'(1);
      else           res = (acc == VEL_MIN) ? VEL_MIN : acc - VEL_W'(1);
      return res;
   endfunction

   logic [SYNC_STAGES-1:0][1:0] ab_sync_q, ab_sync_d;
   logic [1:0]        ab_cand_q, ab_cand_d, prev_q, prev_d, move_s;
   logic [STAB_W-1:0] ab_stab_q, ab_stab_d;
   logic              ab_valid_s, illegal_s;
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              step_q, step_d, dir_q, dir_d, err_q, err_d, ovf_q, ovf_d;
   logic [WIN_W-1:0]  win_q, win_d;
   logic [VEL_W-1:0]  acc_q, acc_d, vel_q, vel_d, acc_sum_s;
   logic              vv_q, vv_d;

   assign ab_valid_s = (ab_stab_q == STAB_FULL);
   assign move_s     = decode_move(prev_q, ab_cand_q);

`ifdef QENC_INDEX_EN
   logic [SYNC_STAGES-1:0] idx_sync_q, idx_sync_d;
   logic [STAB_W-1:0]      idx_stab_q, idx_stab_d;
   logic                   idx_cand_q, idx_cand_d, idx_lvl_q, idx_lvl_d;
   logic                   idx_seen_q, idx_seen_d, idx_valid_s, idx_rise_s;

   assign idx_valid_s = (idx_stab_q == STAB_FULL);
   assign idx_rise_s  = idx_valid_s && idx_cand_q && !idx_lvl_q && (state_q == ST_RUN);

   // Index pin: same sync/filter as A/B; idx_lvl_q holds the last accepted level.
   always_comb begin
      idx_sync_d = {idx_sync_q[SYNC_STAGES-2:0], bus.index_in};
      idx_cand_d = idx_cand_q;
      idx_stab_d = idx_stab_q;
      if (idx_sync_q[SYNC_STAGES-1] != idx_cand_q) begin
         idx_cand_d = idx_sync_q[SYNC_STAGES-1];
         idx_stab_d = STAB_W'(1);
      end else if (!idx_valid_s) begin
         idx_stab_d = idx_stab_q + STAB_W'(1);
      end else begin
         idx_stab_d = idx_stab_q;
      end
      idx_lvl_d = idx_valid_s ? idx_cand_q : idx_lvl_q;
      if (bus.clear)       idx_seen_d = 1'b0;
      else if (idx_rise_s) idx_seen_d = 1'b1;
      else                 idx_seen_d = idx_seen_q;
   end

   // Index path registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_sync_q <= {SYNC_STAGES{1'b0}};
         idx_cand_q <= 1'b0;
         idx_stab_q <= {STAB_W{1'b0}};
         idx_lvl_q  <= 1'b0;
         idx_seen_q <= 1'b0;
      end else begin
         idx_sync_q <= idx_sync_d;
         idx_cand_q <= idx_cand_d;
         idx_stab_q <= idx_stab_d;
         idx_lvl_q  <= idx_lvl_d;
         idx_seen_q <= idx_seen_d;
      end
   end

   assign bus.index_seen = idx_seen_q;
`else
   logic idx_rise_s;
   assign idx_rise_s = 1'b0;
`endif

   // Sync chain and filter: a candidate becomes valid after FILTER_LEN matching samples.
   always_comb begin
      ab_sync_d = {ab_sync_q[SYNC_STAGES-2:0], {bus.a_in, bus.b_in}};
      ab_cand_d = ab_cand_q;
      ab_stab_d = ab_stab_q;
      if (ab_sync_q[SYNC_STAGES-1] != ab_cand_q) begin
         ab_cand_d = ab_sync_q[SYNC_STAGES-1];
         ab_stab_d = STAB_W'(1);
      end else if (!ab_valid_s) begin
         ab_stab_d = ab_stab_q + STAB_W'(1);
      end else begin
         ab_stab_d = ab_stab_q;
      end
   end

   // Decode FSM next state: INIT only latches the first filtered value.
   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      step_d    = 1'b0;
      dir_d     = dir_q;
      illegal_s = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (ab_valid_s) begin
               prev_d  = ab_cand_q;
               state_d = ST_RUN;
            end else begin
               state_d = ST_INIT;
            end
         end
         ST_RUN: begin
            if (ab_valid_s && (ab_cand_q != prev_q)) begin
               prev_d = ab_cand_q;
               case (move_s)
                  MV_UP:   begin step_d = 1'b1; dir_d = 1'b1; end
                  MV_DN:   begin step_d = 1'b1; dir_d = 1'b0; end
                  default: illegal_s = 1'b1;
               endcase
            end else begin
               prev_d = prev_q;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Position, overflow and error; clear and index zeroing override the step.
   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      if (step_d && dir_d) begin
         if (count_q == CNT_MAX) begin
            ovf_d   = 1'b1;
            count_d = (SATURATE != 0) ? CNT_MAX : CNT_MIN;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end else if (step_d) begin
         if (count_q == CNT_MIN) begin
            ovf_d   = 1'b1;
            count_d = (SATURATE != 0) ? CNT_MIN : CNT_MAX;
         end else begin
            count_d = count_q - CNT_W'(1);
         end
      end else begin
         count_d = count_q;
      end
      if (idx_rise_s) count_d = {CNT_W{1'b0}};
      else            count_d = count_d;
      if (bus.clear) begin
         count_d = {CNT_W{1'b0}};
         ovf_d   = 1'b0;
      end else begin
         ovf_d   = ovf_d;
      end
      if (illegal_s)        err_d = 1'b1;
      else if (bus.err_clr) err_d = 1'b0;
      else                  err_d = err_q;
   end

   // Velocity window: accumulate this cycle's step, publish and restart on the last count.
   always_comb begin
      acc_sum_s = vel_add(acc_q, step_d, dir_d);
      if (win_q == WIN_LAST) begin
         win_d = {WIN_W{1'b0}};
         vel_d = acc_sum_s;
         vv_d  = 1'b1;
         acc_d = {VEL_W{1'b0}};
      end else begin
         win_d = win_q + WIN_W'(1);
         vel_d = vel_q;
         vv_d  = 1'b0;
         acc_d = acc_sum_s;
      end
   end

   // Main state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         ab_sync_q <= {(2*SYNC_STAGES){1'b0}};
         ab_cand_q <= 2'b00;
         ab_stab_q <= {STAB_W{1'b0}};
         state_q   <= ST_INIT;
         prev_q    <= 2'b00;
         count_q   <= {CNT_W{1'b0}};
         step_q    <= 1'b0;
         dir_q     <= 1'b0;
         err_q     <= 1'b0;
         ovf_q     <= 1'b0;
         win_q     <= {WIN_W{1'b0}};
         acc_q     <= {VEL_W{1'b0}};
         vel_q     <= {VEL_W{1'b0}};
         vv_q      <= 1'b0;
      end else begin
         ab_sync_q <= ab_sync_d;
         ab_cand_q <= ab_cand_d;
         ab_stab_q <= ab_stab_d;
         state_q   <= state_d;
         prev_q    <= prev_d;
         count_q   <= count_d;
         step_q    <= step_d;
         dir_q     <= dir_d;
         err_q     <= err_d;
         ovf_q     <= ovf_d;
         win_q     <= win_d;
         acc_q     <= acc_d;
         vel_q     <= vel_d;
         vv_q      <= vv_d;
      end
   end

   assign bus.count     = count_q;
   assign bus.step      = step_q;
   assign bus.dir       = dir_q;
   assign bus.err       = err_q;
   assign bus.ovf       = ovf_q;
   assign bus.velocity  = vel_q;
   assign bus.vel_valid = vv_q;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Bench for quad_encoder_counter: a wrapping and a saturating instance (CNT_W=4, VEL_W=4,
// VEL_WINDOW=100) share random pin stimulus and are compared every cycle with a behavioural model.
module tb_quad_encoder_counter;
   localparam int S = 2, F = 4, CW = 4, VW = 4, WIN = 100;
   localparam int CMAX = 7, CMIN = -8, VMAX = 7, VMIN = -8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic a = 1'b0, b = 1'b0, clear = 1'b0, err_clr = 1'b0;
   always #5 clk = ~clk;

   quad_encoder_counter_if #(.CNT_W(CW), .VEL_W(VW)) bw ();
   quad_encoder_counter_if #(.CNT_W(CW), .VEL_W(VW)) bs ();
   assign bw.a_in = a;     assign bs.a_in = a;
   assign bw.b_in = b;     assign bs.b_in = b;
   assign bw.clear = clear;     assign bs.clear = clear;
   assign bw.err_clr = err_clr; assign bs.err_clr = err_clr;
`ifdef QENC_INDEX_EN
   assign bw.index_in = 1'b0;
   assign bs.index_in = 1'b0;
`endif

   quad_encoder_counter #(.SYNC_STAGES(S), .FILTER_LEN(F), .CNT_W(CW), .SATURATE(0),
                          .VEL_WINDOW(WIN), .VEL_W(VW)) dut_w (.clk(clk), .reset(reset), .bus(bw));
   quad_encoder_counter #(.SYNC_STAGES(S), .FILTER_LEN(F), .CNT_W(CW), .SATURATE(1),
                          .VEL_WINDOW(WIN), .VEL_W(VW)) dut_s (.clk(clk), .reset(reset), .bus(bs));

   int checks = 0, failures = 0, cyc = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         if (failures <= 50)
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int gpos(input logic [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   // ---------------- behavioural model ----------------
   logic [1:0] pin_q[$];
   logic [1:0] seen_q[$];
   bit         m_init = 1'b1;
   logic [1:0] m_prev = 2'b00;
   bit         m_step, m_dir, m_err, m_vv;
   int         m_wcnt, m_acc, m_vel;
   int         m_cnt[2];
   bit         m_ovf[2];

   task automatic model_edge();
      bit valid, ill;
      logic [1:0] cur;
      int d, mv, nc, s;
      if (reset) begin
         pin_q.delete(); seen_q.delete();
         m_init = 1'b1; m_prev = 2'b00; m_step = 0; m_dir = 0; m_err = 0; m_vv = 0;
         m_wcnt = 0; m_acc = 0; m_vel = 0;
         for (int k = 0; k < 2; k++) begin m_cnt[k] = 0; m_ovf[k] = 0; end
         return;
      end
      // filtered value is valid when the last F delayed samples all agree
      valid = (seen_q.size() == F);
      foreach (seen_q[i]) if (seen_q[i] != seen_q[0]) valid = 0;
      cur = (seen_q.size() > 0) ? seen_q[seen_q.size()-1] : 2'b00;
      pin_q.push_back({a, b});
      if (pin_q.size() > S + 1) void'(pin_q.pop_front());
      seen_q.push_back((pin_q.size() == S + 1) ? pin_q[0] : 2'b00);
      if (seen_q.size() > F) void'(seen_q.pop_front());

      d = 0; ill = 0; m_step = 0;
      if (m_init) begin
         if (valid) begin m_prev = cur; m_init = 0; end
      end else if (valid && cur != m_prev) begin
         mv = (gpos(cur) - gpos(m_prev) + 4) % 4;
         if (mv == 1) d = 1;
         else if (mv == 3) d = -1;
         else ill = 1;
         m_prev = cur;
      end
      if (d != 0) begin m_step = 1; m_dir = (d > 0); end
      for (int k = 0; k < 2; k++) begin
         nc = m_cnt[k] + d;
         if (nc > CMAX) begin m_ovf[k] = 1; nc = (k == 0) ? CMIN : CMAX; end
         else if (nc < CMIN) begin m_ovf[k] = 1; nc = (k == 0) ? CMAX : CMIN; end
         m_cnt[k] = nc;
         if (clear) begin m_cnt[k] = 0; m_ovf[k] = 0; end
      end
      if (ill) m_err = 1;
      else if (err_clr) m_err = 0;
      s = m_acc + d;
      if (s > VMAX) s = VMAX;
      if (s < VMIN) s = VMIN;
      if (m_wcnt == WIN - 1) begin m_vel = s; m_vv = 1; m_acc = 0; end
      else begin m_acc = s; m_vv = 0; end
      m_wcnt = (m_wcnt + 1) % WIN;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         model_edge();
      end
   end

   // per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         if (cyc > 0) begin
            chk("w_step", bw.step, m_step);       chk("s_step", bs.step, m_step);
            chk("w_dir", bw.dir, m_dir);          chk("s_dir", bs.dir, m_dir);
            chk("w_err", bw.err, m_err);          chk("s_err", bs.err, m_err);
            chk("w_count", int'($signed(bw.count)), m_cnt[0]);
            chk("s_count", int'($signed(bs.count)), m_cnt[1]);
            chk("w_ovf", bw.ovf, m_ovf[0]);       chk("s_ovf", bs.ovf, m_ovf[1]);
            chk("w_vel", int'($signed(bw.velocity)), m_vel);
            chk("s_vel", int'($signed(bs.velocity)), m_vel);
            chk("w_vv", bw.vel_valid, m_vv);      chk("s_vv", bs.vel_valid, m_vv);
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
   logic [1:0] gcur = 2'b00;
   int  nstep_w = 0, nstep_s = 0, since = 0, lat = -1, t0 = 0;
   bit  armed = 0, rnd_ctl = 0, ok;

   task automatic tick();
      @(negedge clk);
      since++;
      if (bw.step) nstep_w++;
      if (bs.step) nstep_s++;
      if (armed && bw.step) begin lat = since; armed = 0; end
      if (rnd_ctl) begin
         clear   = ($urandom_range(0, 99) < 2);
         err_clr = ($urandom_range(0, 99) < 4);
      end
   endtask

   task automatic drive(input logic [1:0] v, input int hold);
      {a, b} = v;
      since = 0; armed = 1; lat = -1;
      repeat (hold) tick();
   endtask

   task automatic gstep(input bit up, input int hold);
      gcur = gray_tab[(gpos(gcur) + (up ? 1 : 3)) % 4];
      drive(gcur, hold);
   endtask

   task automatic wait_vv(input int bound, output bit seen);
      seen = 0;
      for (int i = 0; i < bound && !seen; i++) begin
         tick();
         if (bw.vel_valid) seen = 1;
      end
   endtask

   task automatic do_reset(input logic [1:0] v, input int n);
      reset = 1'b1; gcur = v; {a, b} = v;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   initial begin
      do_reset(2'b00, 3);
      chk("rst_count", int'($signed(bw.count)), 0);
      chk("rst_step", bw.step, 0);
      chk("rst_err", bw.err, 0);
      chk("rst_ovf", bw.ovf, 0);
      chk("rst_vel", int'($signed(bw.velocity)), 0);
      chk("rst_vv", bw.vel_valid, 0);

      // INIT with pins at 11: no step, no error
      nstep_w = 0;
      gcur = 2'b11; drive(gcur, 20);
      chk("init_steps", nstep_w, 0);
      chk("init_count", int'($signed(bw.count)), 0);
      chk("init_err", bw.err, 0);

      // forward then reverse Gray walk, each edge 7 cycles to step
      do_reset(2'b00, 2);
      drive(2'b00, 20);
      nstep_w = 0;
      for (int i = 0; i < 4; i++) begin gstep(1, 10); chk("lat_up", lat, 7); end
      chk("up_steps", nstep_w, 4);
      chk("up_count", int'($signed(bw.count)), 4);
      chk("up_dir", bw.dir, 1);
      for (int i = 0; i < 4; i++) begin gstep(0, 10); chk("lat_dn", lat, 7); end
      chk("dn_count", int'($signed(bw.count)), 0);
      chk("dn_dir", bw.dir, 0);

      // 3-cycle glitch is rejected; 00->11 flags err without counting
      nstep_w = 0;
      drive(2'b10, 3);
      drive(2'b00, 10);
      chk("glitch_steps", nstep_w, 0);
      gcur = 2'b11; drive(gcur, 10);
      chk("ill_err", bw.err, 1);
      chk("ill_steps", nstep_w, 0);
      chk("ill_count", int'($signed(bw.count)), 0);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("errclr", bw.err, 0);

      // 8 up steps from 0: wrap to -8 / saturate at 7
      nstep_w = 0; nstep_s = 0;
      for (int i = 0; i < 8; i++) gstep(1, 10);
      chk("wrap_count", int'($signed(bw.count)), -8);
      chk("wrap_ovf", bw.ovf, 1);
      chk("sat_count", int'($signed(bs.count)), 7);
      chk("sat_ovf", bs.ovf, 1);
      chk("sat_steps", nstep_s, 8);
      chk("wrap_steps", nstep_w, 8);
      clear = 1'b1; tick(); clear = 1'b0;
      chk("clr_count", int'($signed(bs.count)), 0);
      chk("clr_ovf", bs.ovf, 0);

      // velocity over aligned windows: +5 then -3
      wait_vv(150, ok); chk("vv_seen0", ok, 1);
      t0 = cyc;
      for (int i = 0; i < 5; i++) gstep(1, 10);
      wait_vv(100, ok); chk("vv_seen1", ok, 1);
      chk("vv_period1", cyc - t0, 100);
      chk("vel_plus5", int'($signed(bw.velocity)), 5);
      t0 = cyc;
      for (int i = 0; i < 3; i++) gstep(0, 10);
      wait_vv(100, ok); chk("vv_seen2", ok, 1);
      chk("vv_period2", cyc - t0, 100);
      chk("vel_minus3", int'($signed(bw.velocity)), -3);

      // randomized phase
      rnd_ctl = 1;
      for (int op = 0; op < 300; op++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 55) begin
            gstep($urandom_range(0, 1) == 1, $urandom_range(5, 14));
         end else if (r < 70) begin
            drive(gcur ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01), $urandom_range(1, 3));
            drive(gcur, $urandom_range(3, 8));
         end else if (r < 82) begin
            gcur = ~gcur; drive(gcur, $urandom_range(5, 12));
         end else if (r < 88) begin
            gcur = 2'($urandom_range(0, 3)); drive(gcur, $urandom_range(1, 12));
         end else if (r < 90) begin
            do_reset(2'($urandom_range(0, 3)), $urandom_range(1, 2));
         end else begin
            repeat ($urandom_range(1, 20)) tick();
         end
      end
      rnd_ctl = 0; clear = 1'b0; err_clr = 1'b0;
      repeat (10) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
